window_sum_sched: RTL and testbench

//  Shares one sliding-window adder between two sample requesters (ch0, ch1).

---
 rtl/window_sum_pkg.sv | 22 ++
 rtl/rr_arb2.sv | 24 ++
 rtl/window_sum_sched.sv | 111 +++++++++++
 tb/tb_window_sum_sched.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/window_sum_pkg.sv
// Shared constants, channel type and the window-sum overflow policy.
// WINDOW_SUM_SATURATE_EN selects clamping instead of modulo wrap.
package window_sum_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int TAPS_DEF   = 3;
  localparam int NUM_CH     = 2;

  typedef logic ch_t;

  // Reduces a full-width window sum to data_w bits (result in the low bits).
  function automatic logic [31:0] win_add(input logic [31:0] full_sum, input int data_w);
    logic [31:0] max_val;
    max_val = (32'd1 << data_w) - 32'd1;
`ifdef WINDOW_SUM_SATURATE_EN
    return (full_sum > max_val) ? max_val : full_sum;
`else
    return full_sum & max_val;
`endif
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter; the loser of the previous grant wins a tie.
module rr_arb2
  import window_sum_pkg::*;
(
  input  logic [1:0] req,
  input  logic       stall,
  input  logic       clear,
  input  ch_t        last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (!(stall || clear)) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/window_sum_sched.sv
// Two-channel sliding-window sum sharing one adder behind a round-robin arbiter.
// Define WINDOW_SUM_SATURATE_EN to clamp sums on overflow instead of wrapping.
module window_sum_sched
  import window_sum_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TAPS   = TAPS_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic [1:0]        in_valid,
  output logic [1:0]        in_ready,
  input  logic [DATA_W-1:0] in_data0,
  input  logic [DATA_W-1:0] in_data1,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_ch,
  output logic [DATA_W-1:0] out_sum
);

  localparam int SUM_W  = DATA_W + 3;
  localparam int HIST_N = TAPS - 1;

  logic [HIST_N-1:0][DATA_W-1:0] hist_reg [NUM_CH];
  logic [DATA_W-1:0]             in_data_arr [NUM_CH];
  logic                          out_valid_reg;
  logic [DATA_W-1:0]             out_sum_reg;
  ch_t                           out_ch_reg;
  ch_t                           last_grant_reg;

  logic              stall;
  logic [1:0]        gnt;
  logic [1:0]        xfer;
  logic              xfer_any;
  ch_t               sel_ch;
  logic [DATA_W-1:0] data_sel;
  logic [SUM_W-1:0]  sum_full;
  logic [DATA_W-1:0] sum_next;

  assign in_data_arr[0] = in_data0;
  assign in_data_arr[1] = in_data1;

  assign stall = out_valid_reg & ~out_ready;

  rr_arb2 u_arb (
    .req        (in_valid),
    .stall      (stall),
    .clear      (clear),
    .last_grant (last_grant_reg),
    .gnt        (gnt)
  );

  assign in_ready = gnt;
  assign xfer     = in_valid & gnt;
  assign xfer_any = |xfer;
  assign sel_ch   = gnt[1];
  assign data_sel = in_data_arr[sel_ch];

  // The single shared adder works on whichever channel holds the grant.
  always_comb begin
    sum_full = SUM_W'(data_sel);
    for (int k = 0; k < HIST_N; k++) begin
      sum_full = sum_full + SUM_W'(hist_reg[sel_ch][k]);
    end
  end

  assign sum_next = DATA_W'(win_add(32'(sum_full), DATA_W));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_hist
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          hist_reg[gi] <= '0;
        end else if (clear) begin
          hist_reg[gi] <= '0;
        end else if (xfer[gi]) begin
          hist_reg[gi][0] <= in_data_arr[gi];
          for (int k = 1; k < HIST_N; k++) begin
            hist_reg[gi][k] <= hist_reg[gi][k-1];
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_reg  <= 1'b0;
      out_sum_reg    <= '0;
      out_ch_reg     <= 1'b0;
      last_grant_reg <= 1'b1;
    end else if (clear) begin
      out_valid_reg  <= 1'b0;
      last_grant_reg <= 1'b1;
    end else if (xfer_any) begin
      out_valid_reg  <= 1'b1;
      out_sum_reg    <= sum_next;
      out_ch_reg     <= sel_ch;
      last_grant_reg <= sel_ch;
    end else if (out_valid_reg && out_ready) begin
      out_valid_reg  <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_sum   = out_sum_reg;
  assign out_ch    = out_ch_reg;

endmodule

// File: tb/tb_window_sum_sched.sv
// Directed bench for window_sum_sched (DATA_W=8, TAPS=3), honours WINDOW_SUM_SATURATE_EN.
module tb_window_sum_sched;

  logic       clk;
  logic       reset_n;
  logic       clear;
  logic [1:0] in_valid;
  logic [1:0] in_ready;
  logic [7:0] in_data0;
  logic [7:0] in_data1;
  logic       out_valid;
  logic       out_ready;
  logic       out_ch;
  logic [7:0] out_sum;

  int n_checks = 0;
  int n_fail   = 0;

  window_sum_sched #(.DATA_W(8), .TAPS(3)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data0  (in_data0),
    .in_data1  (in_data1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_sum   (out_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1);
    in_valid = v;
    in_data0 = d0;
    in_data1 = d1;
  endtask

  task automatic do_clear();
    drive(2'b00, 8'd0, 8'd0);
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  // Accept one sample and check the result registered on the next edge.
  task automatic xfer_chk(input string tag, input logic [1:0] v, input logic [7:0] d0,
                          input logic [7:0] d1, input logic [1:0] exp_rdy,
                          input logic exp_ch, input logic [7:0] exp_sum);
    drive(v, d0, d1);
    check({tag, ".rdy"}, 32'(in_ready), 32'(exp_rdy));
    step();
    check({tag, ".vld"}, 32'(out_valid), 32'd1);
    check({tag, ".ch"},  32'(out_ch),    32'(exp_ch));
    check({tag, ".sum"}, 32'(out_sum),   32'(exp_sum));
  endtask

  logic [7:0] ch1_third;
  logic [7:0] t1 [4];
  logic [7:0] e1 [4];

  initial begin
    reset_n   = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b1;
    drive(2'b00, 8'd0, 8'd0);
    #12;
    check("rst.vld", 32'(out_valid), 32'd0);
    check("rst.sum", 32'(out_sum),   32'd0);
    check("rst.ch",  32'(out_ch),    32'd0);
    check("rst.rdy", 32'(in_ready),  32'd0);
    reset_n = 1'b1;
    step();

    // 1: ch0 running sums
    t1 = '{8'd10, 8'd20, 8'd30, 8'd40};
    e1 = '{8'd10, 8'd30, 8'd60, 8'd90};
    for (int i = 0; i < 4; i++) begin
      xfer_chk($sformatf("t1.s%0d", i), 2'b01, t1[i], 8'd0, 2'b01, 1'b0, e1[i]);
    end
    drive(2'b00, 8'd0, 8'd0);
    step();
    check("t1.pop.vld", 32'(out_valid), 32'd0);
    check("t1.pop.sum", 32'(out_sum),   32'd90);
    do_clear();

    // 2: both requesting, alternating grants
`ifdef WINDOW_SUM_SATURATE_EN
    ch1_third = 8'd255;
`else
    ch1_third = 8'd44;
`endif
    xfer_chk("t2.g0", 2'b11, 8'd1, 8'd100, 2'b01, 1'b0, 8'd1);
    xfer_chk("t2.g1", 2'b11, 8'd1, 8'd100, 2'b10, 1'b1, 8'd100);
    xfer_chk("t2.g2", 2'b11, 8'd1, 8'd100, 2'b01, 1'b0, 8'd2);
    xfer_chk("t2.g3", 2'b11, 8'd1, 8'd100, 2'b10, 1'b1, 8'd200);
    xfer_chk("t2.g4", 2'b11, 8'd1, 8'd100, 2'b01, 1'b0, 8'd3);
    xfer_chk("t2.g5", 2'b11, 8'd1, 8'd100, 2'b10, 1'b1, ch1_third);
    xfer_chk("t2.g6", 2'b11, 8'd1, 8'd100, 2'b01, 1'b0, 8'd3);
    do_clear();

    // 3: backpressure holds the result and blocks new requests
    xfer_chk("t3.s0", 2'b01, 8'd10, 8'd0, 2'b01, 1'b0, 8'd10);
    out_ready = 1'b0;
    drive(2'b11, 8'd20, 8'd50);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t3.stall%0d.rdy", i), 32'(in_ready), 32'd0);
      step();
      check($sformatf("t3.stall%0d.vld", i), 32'(out_valid), 32'd1);
      check($sformatf("t3.stall%0d.sum", i), 32'(out_sum),   32'd10);
      check($sformatf("t3.stall%0d.ch", i),  32'(out_ch),    32'd0);
    end
    out_ready = 1'b1;
    xfer_chk("t3.resume", 2'b01, 8'd20, 8'd0, 2'b01, 1'b0, 8'd30);
    drive(2'b00, 8'd0, 8'd0);
    step();
    check("t3.drain.vld", 32'(out_valid), 32'd0);
    do_clear();

    // 4: clear flushes history and blocks the same-cycle request
    xfer_chk("t4.s0", 2'b01, 8'd50, 8'd0, 2'b01, 1'b0, 8'd50);
    xfer_chk("t4.s1", 2'b01, 8'd60, 8'd0, 2'b01, 1'b0, 8'd110);
    xfer_chk("t4.s2", 2'b01, 8'd70, 8'd0, 2'b01, 1'b0, 8'd180);
    drive(2'b01, 8'd99, 8'd0);
    clear = 1'b1;
    #1;
    check("t4.clr.rdy", 32'(in_ready), 32'd0);
    step();
    clear = 1'b0;
    check("t4.clr.vld", 32'(out_valid), 32'd0);
    xfer_chk("t4.after", 2'b01, 8'd5, 8'd0, 2'b01, 1'b0, 8'd5);

    // 5: asynchronous reset mid-stream
    xfer_chk("t5.pre0", 2'b01, 8'd40, 8'd0, 2'b01, 1'b0, 8'd45);
    xfer_chk("t5.pre1", 2'b10, 8'd0, 8'd33, 2'b10, 1'b1, 8'd33);
    drive(2'b00, 8'd0, 8'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check("t5.rst.vld", 32'(out_valid), 32'd0);
    check("t5.rst.sum", 32'(out_sum),   32'd0);
    #3;
    reset_n = 1'b1;
    step();
    xfer_chk("t5.tie0", 2'b11, 8'd7, 8'd9, 2'b01, 1'b0, 8'd7);
    xfer_chk("t5.tie1", 2'b11, 8'd7, 8'd9, 2'b10, 1'b1, 8'd9);
    do_clear();

    // 6: interleaved channels stay isolated
    xfer_chk("t6.c0a", 2'b01, 8'd1,  8'd0,  2'b01, 1'b0, 8'd1);
    xfer_chk("t6.c1a", 2'b10, 8'd0,  8'd10, 2'b10, 1'b1, 8'd10);
    xfer_chk("t6.c0b", 2'b01, 8'd2,  8'd0,  2'b01, 1'b0, 8'd3);
    xfer_chk("t6.c1b", 2'b10, 8'd0,  8'd20, 2'b10, 1'b1, 8'd30);
    xfer_chk("t6.c0c", 2'b01, 8'd3,  8'd0,  2'b01, 1'b0, 8'd6);
    xfer_chk("t6.c1c", 2'b10, 8'd0,  8'd30, 2'b10, 1'b1, 8'd60);
    drive(2'b00, 8'd0, 8'd0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
